// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared opcodes, forward codes and shadow-stage types for the hazard/forwarding controller.
// Used by hazard_fwd_ctrl, hazard_src_use and hazard_fwd_ctrl_if.
package hazard_fwd_ctrl_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [4:0] reg_idx_t;

    localparam opcode_t R_TYPE  = 7'b0110011;
    localparam opcode_t I_IMM   = 7'b0010011;
    localparam opcode_t I_LOAD  = 7'b0000011;
    localparam opcode_t S_TYPE  = 7'b0100011;
    localparam opcode_t B_TYPE  = 7'b1100011;
    localparam opcode_t J_JAL   = 7'b1101111;
    localparam opcode_t I_JALR  = 7'b1100111;
    localparam opcode_t U_LUI   = 7'b0110111;
    localparam opcode_t U_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        FW_NONE  = 2'b00,
        FW_EXMEM = 2'b01,
        FW_MEMWB = 2'b10
    } fw_code_e;

    typedef struct packed {
        logic     valid;
        opcode_t  op;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     regwrite;
        logic     isload;
    } idex_t;

    // Reduced view of a stage: only what matters for producing a result.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
    } writer_t;

    // x0 is hardwired, so a writer targeting it never produces a dependency.
    function automatic logic writer_matches(writer_t w, reg_idx_t r);
        return w.valid & w.regwrite & (w.rd != 5'd0) & (w.rd == r);
    endfunction

    function automatic logic src_hit(writer_t w, logic use1, logic use2,
                                     reg_idx_t rs1, reg_idx_t rs2);
        return (use1 & writer_matches(w, rs1)) | (use2 & writer_matches(w, rs2));
    endfunction

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic fw_code_e pick_fwd(logic use_src, reg_idx_t r,
                                          writer_t exmem, writer_t memwb);
        if (use_src && writer_matches(exmem, r))
            return FW_EXMEM;
        if (use_src && writer_matches(memwb, r))
            return FW_MEMWB;
        return FW_NONE;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side bus between the ID stage and the hazard/forwarding controller.
interface hazard_fwd_ctrl_if;
    import hazard_fwd_ctrl_pkg::*;

    logic     id_valid;
    opcode_t  id_op;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    reg_idx_t id_rd;
    logic     id_regwrite;
    logic     flush;
    logic     stall;
    logic [1:0] forwA;
    logic [1:0] forwB;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, id_regwrite, flush,
        input  stall, forwA, forwB
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_regwrite, flush,
        output stall, forwA, forwB
    );
endinterface

// File: rtl/hazard_src_use.sv
// Opcode decoder: which register source fields an instruction actually reads.
module hazard_src_use
    import hazard_fwd_ctrl_pkg::*;
(
    input  opcode_t op,
    output logic    uses_rs1,
    output logic    uses_rs2
);
    assign uses_rs1 = !((op == U_LUI) || (op == U_AUIPC) || (op == J_JAL));
    assign uses_rs2 = (op == R_TYPE) || (op == S_TYPE) || (op == B_TYPE);
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and EX operand-forwarding control for the 5-stage RV32I pipeline.
// Define HAZ_STATS_EN to build the saturating stall/forward performance counters.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             isForw_ON,
    hazard_fwd_ctrl_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    idex_t   idex_q;
    writer_t exmem_q;
    writer_t memwb_q;
    writer_t idex_wr;

    logic id_use1, id_use2;
    logic ex_use1, ex_use2;

    hazard_src_use u_id_use (
        .op       (bus.id_op),
        .uses_rs1 (id_use1),
        .uses_rs2 (id_use2)
    );

    hazard_src_use u_ex_use (
        .op       (idex_q.op),
        .uses_rs1 (ex_use1),
        .uses_rs2 (ex_use2)
    );

    assign idex_wr = '{valid: idex_q.valid, rd: idex_q.rd, regwrite: idex_q.regwrite};

    fw_code_e fw_a, fw_b;
    logic     load_use, interlock_hit, stall_c;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        fw_a = FW_NONE;
        fw_b = FW_NONE;
        if (isForw_ON && idex_q.valid) begin
            fw_a = pick_fwd(ex_use1, idex_q.rs1, exmem_q, memwb_q);
            fw_b = pick_fwd(ex_use2, idex_q.rs2, exmem_q, memwb_q);
        end
    end

    always_comb begin
        load_use      = idex_q.isload
                      & src_hit(idex_wr, id_use1, id_use2, bus.id_rs1, bus.id_rs2);
        interlock_hit = src_hit(idex_wr, id_use1, id_use2, bus.id_rs1, bus.id_rs2)
                      | src_hit(exmem_q, id_use1, id_use2, bus.id_rs1, bus.id_rs2)
                      | src_hit(memwb_q, id_use1, id_use2, bus.id_rs1, bus.id_rs2);
        stall_c       = 1'b0;
        // A redirect squashes the ID instruction, so holding it would be pointless.
        if (bus.id_valid && !bus.flush)
            stall_c = isForw_ON ? load_use : interlock_hit;
    end

    assign bus.stall = stall_c;
    assign bus.forwA = fw_a;
    assign bus.forwB = fw_b;

    // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            exmem_q <= idex_wr;
            memwb_q <= exmem_q;
            if (stall_c) begin
                idex_q <= '0;
            end else begin
                idex_q <= '{valid:    bus.id_valid & ~bus.flush,
                            op:       bus.id_op,
                            rs1:      bus.id_rs1,
                            rs2:      bus.id_rs2,
                            rd:       bus.id_rd,
                            regwrite: bus.id_regwrite,
                            isload:   (bus.id_op == I_LOAD)};
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic any_fwd;
    assign any_fwd = (fw_a != FW_NONE) || (fw_b != FW_NONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (any_fwd && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl; expected values are hand-derived pipeline timelines.
module tb_hazard_fwd_ctrl;
    import hazard_fwd_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             is_forw_on;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    hazard_fwd_ctrl_if bus ();

    hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .isForw_ON (is_forw_on),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counters read as zero when the statistics option is not built.
    task automatic check_cnt(input string tag, input int s_exp, input int f_exp);
`ifdef HAZ_STATS_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(s_exp));
        check({tag, "_fwd_cnt"},   32'(fwd_cnt),   32'(f_exp));
`else
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(s_exp * 0));
        check({tag, "_fwd_cnt"},   32'(fwd_cnt),   32'(f_exp * 0));
`endif
    endtask

    task automatic check_out(input string tag, input logic s, input logic [1:0] fa,
                             input logic [1:0] fb);
        check({tag, "_stall"}, 32'(bus.stall), 32'(s));
        check({tag, "_forwA"}, 32'(bus.forwA), 32'(fa));
        check({tag, "_forwB"}, 32'(bus.forwB), 32'(fb));
    endtask

    // Presents one instruction in ID for the coming cycle; returns mid-cycle, away from the edge.
    task automatic issue(input logic v, input opcode_t op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                         input logic fl);
        @(posedge clk);
        #1;
        bus.id_valid    = v;
        bus.id_op       = op;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.flush       = fl;
        #1;
    endtask

    task automatic nop();
        issue(1'b1, I_IMM, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input logic fwd);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        is_forw_on   = fwd;
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        is_forw_on      = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_op       = I_IMM;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_regwrite = 1'b0;
        bus.flush       = 1'b0;

        do_reset(1'b1);
        check_out("reset", 1'b0, 2'b00, 2'b00);
        check_cnt("reset", 0, 0);

        // add x1,x2,x3 ; add x4,x1,x1 -> both operands from EX/MEM
        issue(1'b1, R_TYPE, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        check("t1_c1_stall", 32'(bus.stall), 32'd0);
        issue(1'b1, R_TYPE, 5'd1, 5'd1, 5'd4, 1'b1, 1'b0);
        check_out("t1_c2", 1'b0, 2'b00, 2'b00);
        nop();
        check_out("t1_ex", 1'b0, 2'b01, 2'b01);
        nop();
        check_out("t1_after", 1'b0, 2'b00, 2'b00);

        // add x1 ; nop ; sub x5,x1,x7 -> forwA from MEM/WB
        do_reset(1'b1);
        issue(1'b1, R_TYPE, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        nop();
        issue(1'b1, R_TYPE, 5'd1, 5'd7, 5'd5, 1'b1, 1'b0);
        check("t2_c3_stall", 32'(bus.stall), 32'd0);
        nop();
        check_out("t2_ex", 1'b0, 2'b10, 2'b00);

        // add x1 ; add x1 ; sub x5,x7,x1 -> EX/MEM wins over MEM/WB on forwB
        do_reset(1'b1);
        issue(1'b1, R_TYPE, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        issue(1'b1, R_TYPE, 5'd4, 5'd5, 5'd1, 1'b1, 1'b0);
        issue(1'b1, R_TYPE, 5'd7, 5'd1, 5'd5, 1'b1, 1'b0);
        nop();
        check_out("t2b_prio", 1'b0, 2'b00, 2'b01);

        // lw x5,0(x2) ; add x6,x5,x0 -> one stall, then MEM/WB forward
        do_reset(1'b1);
        issue(1'b1, I_LOAD, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
        issue(1'b1, R_TYPE, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        check_out("t3_hazard", 1'b1, 2'b00, 2'b00);
        issue(1'b1, R_TYPE, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        check_out("t3_bubble", 1'b0, 2'b00, 2'b00);
        nop();
        check_out("t3_ex", 1'b0, 2'b10, 2'b00);
        nop();
        check_cnt("t3", 1, 1);

        // addi x0,x0,5 ; add x3,x0,x0 -> x0 never forwards
        do_reset(1'b1);
        issue(1'b1, I_IMM, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(1'b1, R_TYPE, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        check("t4_x0_stall", 32'(bus.stall), 32'd0);
        nop();
        check_out("t4_x0_ex", 1'b0, 2'b00, 2'b00);

        // interlock mode: lui x7 ; sw x7,0(x0) -> three stalls, then forwB = 00
        do_reset(1'b0);
        issue(1'b1, U_LUI, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, S_TYPE, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
            check($sformatf("t4_sw_stall%0d", i), 32'(bus.stall), (i < 3) ? 32'd1 : 32'd0);
        end
        nop();
        check_out("t4_sw_ex", 1'b0, 2'b00, 2'b00);
        check_cnt("t4", 3, 0);

        // lw x5 ; dependent add with flush in the hazard cycle -> no stall, bubble
        do_reset(1'b1);
        issue(1'b1, I_LOAD, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
        issue(1'b1, R_TYPE, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
        check("t5_flush_stall", 32'(bus.stall), 32'd0);
        nop();
        check_out("t5_c3", 1'b0, 2'b00, 2'b00);
        nop();
        check_out("t5_c4", 1'b0, 2'b00, 2'b00);
        check_cnt("t5", 0, 0);

        // interlock mode, reset pulse in the middle of a stall
        do_reset(1'b0);
        issue(1'b1, U_LUI, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(1'b1, S_TYPE, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        check("t6_stall_a", 32'(bus.stall), 32'd1);
        issue(1'b1, S_TYPE, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        check("t6_stall_b", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        issue(1'b1, S_TYPE, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_out("t6_after_rst", 1'b0, 2'b00, 2'b00);
        check_cnt("t6", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
